// File: rtl/adder_seq.sv
// adder_seq: multi-cycle digit-serial add/sub/adc/sbb with valid/ready handshakes
module adder_seq #(
  parameter int W = 32,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         c,
  output logic         o,
  output logic         z
);
  localparam int NDIG = W / D;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [W-1:0] xr, tr, s_nx;
  logic [CW-1:0] cnt;
  logic cy, cf, last;
  logic [D:0] dsum;
  // one digit of the narrow adder and the full result it produces
  always_comb begin
    dsum = {1'b0, xr[cnt*D +: D]} + {1'b0, tr[cnt*D +: D]} + {{D{1'b0}}, cy};
    s_nx = s;
    s_nx[cnt*D +: D] = dsum[D-1:0];
    last = cnt == CW'(NDIG - 1);
  end
  // control FSM with registered handshakes, digit datapath and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      s <= '0;
      c <= 1'b0;
      o <= 1'b0;
      z <= 1'b0;
      cf <= 1'b0;
      cnt <= '0;
      cy <= 1'b0;
      xr <= '0;
      tr <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          xr <= x;
          tr <= {W{op[0]}} ^ y;
          cy <= op[1] ? cf : op[0];
          s <= '0;
          cnt <= '0;
          in_ready <= 1'b0;
          state <= BUSY;
        end
        BUSY: begin
          s <= s_nx;
          cy <= dsum[D];
          cnt <= last ? cnt : cnt + 1'b1;
          if (last) begin
            c <= dsum[D];
            o <= ~(xr[W-1] ^ tr[W-1]) & (s_nx[W-1] ^ xr[W-1]);
            z <= ~|s_nx;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          cf <= c;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq: directed vectors against hand-computed results
module tb_adder_seq;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 0;
  logic [31:0] x = 0, y = 0;
  logic [1:0] op = 0;
  logic in_ready, out_valid, c, o, z;
  logic [31:0] s;
  logic iv8 = 0, or8 = 0, ir8, ov8, c8, o8, z8;
  logic [7:0] x8 = 0, y8 = 0, s8;
  logic [1:0] op8 = 0;
  logic iv16 = 0, or16 = 0, ir16, ov16, c16, o16, z16;
  logic [15:0] x16 = 0, y16 = 0, s16;
  logic [1:0] op16 = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  adder_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .op(op), .out_valid(out_valid), .out_ready(out_ready), .s(s), .c(c), .o(o), .z(z));
  adder_seq #(.W(8), .D(8)) dut8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8),
    .y(y8), .op(op8), .out_valid(ov8), .out_ready(or8), .s(s8), .c(c8), .o(o8), .z(z8));
  adder_seq #(.W(16), .D(4)) dut16 (.clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .x(x16), .y(y16), .op(op16), .out_valid(ov16), .out_ready(or16), .s(s16), .c(c16), .o(o16),
    .z(z16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] p, input logic [31:0] es, input logic ec,
                     input logic eo, input logic ez);
    int n;
    x = a; y = b; op = p; in_valid = 1;
    tick();
    in_valid = 0;
    chk({tag, "_busy_rdy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_s"}, s, es);
    chk({tag, "_c"}, c, ec);
    chk({tag, "_o"}, o, eo);
    chk({tag, "_z"}, z, ez);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_rdy"}, in_ready, 1);
  endtask

  initial begin
    int n, l8, l16;
    tick();
    tick();
    rst = 0;
    chk("rst_rdy", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_flags", {c, o, z}, 0);

    run("add_ovf", 32'h7FFFFFFF, 32'h1, 2'b00, 32'h80000000, 0, 1, 0);
    run("sub_eq", 32'd5, 32'd5, 2'b01, 32'h0, 1, 0, 1);
    run("sub_neg", 32'd3, 32'd5, 2'b01, 32'hFFFFFFFE, 0, 0, 0);
    run("add_wrap", 32'hFFFFFFFF, 32'h1, 2'b00, 32'h0, 1, 0, 1);
    run("adc_cf1", 32'h0, 32'h0, 2'b10, 32'h1, 0, 0, 0);
    run("adc_cf0", 32'h0, 32'h0, 2'b10, 32'h0, 0, 0, 1);

    x = 32'h12345678; y = 32'h11111111; op = 2'b00; in_valid = 1;
    tick();
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_lat", n, 4);
    for (int i = 0; i < 6; i++) begin
      chk("bp_s", s, 32'h23456789);
      chk("bp_ov", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      tick();
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("bp_ov_drop", out_valid, 0);
    chk("bp_rdy_back", in_ready, 1);
    in_valid = 0;
    tick();
    chk("bp_no_accept", in_ready, 1);

    run("set_cf", 32'hFFFFFFFF, 32'h1, 2'b00, 32'h0, 1, 0, 1);
    x = 32'hFFFFFFFF; y = 32'h1; op = 2'b00; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_s", s, 0);
    run("sbb_cf0", 32'd5, 32'd3, 2'b11, 32'h1, 1, 0, 0);

    x8 = 8'h80; y8 = 8'h01; op8 = 2'b01; iv8 = 1;
    x16 = 16'h8000; y16 = 16'h0001; op16 = 2'b01; iv16 = 1;
    tick();
    iv8 = 0;
    iv16 = 0;
    l8 = -1;
    l16 = -1;
    for (int i = 1; i <= 20; i++) begin
      if (ov8 && l8 < 0) l8 = i - 1;
      if (ov16 && l16 < 0) l16 = i - 1;
      tick();
    end
    chk("w8_lat", l8, 1);
    chk("w8_s", s8, 8'h7F);
    chk("w8_co", {c8, o8, z8}, 3'b110);
    chk("w16_lat", l16, 4);
    chk("w16_s", s16, 16'h7FFF);
    chk("w16_co", {c16, o16, z16}, 3'b110);
    or8 = 1;
    or16 = 1;
    tick();
    or8 = 0;
    or16 = 0;
    chk("w8_done", {ov8, ir8}, 2'b01);
    chk("w16_done", {ov16, ir16}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
